// File: rtl/path_walker.sv
// ============================================================================
//  Module      : path_walker
//  Description : Follows the path_dir pointers of a converged node grid from
//                a goal cell back to its source cell and streams every visited
//                coordinate and cost over a valid/ready interface. The grid is
//                read through a registered single-port lookup with one cycle
//                of latency.
//                Optional build macro PATH_WALKER_MONO_CHECK_EN adds a check
//                that costs strictly decrease along the walk (err = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module path_walker #(
    parameter int W         = 32,
    parameter int H         = 32,
    parameter int XW        = 5,
    parameter int YW        = 5,
    parameter int MAX_STEPS = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [XW-1:0] goal_x,
    input  logic [YW-1:0] goal_y,
    output logic          rd_en,
    output logic [XW-1:0] rd_x,
    output logic [YW-1:0] rd_y,
    input  logic [3:0]    rd_dir,
    input  logic [11:0]   rd_cost,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y,
    output logic [11:0]   out_cost,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic [2:0]    err
);

    localparam int c_step_w = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
    localparam logic [c_step_w-1:0] c_last_step = c_step_w'(MAX_STEPS - 1);
    localparam logic signed [XW:0]  c_x_max     = (XW + 1)'(W - 1);
    localparam logic signed [YW:0]  c_y_max     = (YW + 1)'(H - 1);
    localparam logic signed [XW:0]  c_x_pos     = (XW + 1)'(1);
    localparam logic signed [YW:0]  c_y_pos     = (YW + 1)'(1);
    localparam logic [11:0]         c_unreach   = 12'hFFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WAIT = 3'd2,
        ST_EMIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_rd_en;
    logic [XW-1:0]         r_cur_x;
    logic [YW-1:0]         r_cur_y;
    logic [XW-1:0]         r_next_x;
    logic [YW-1:0]         r_next_y;
    logic [11:0]           r_cost;
    logic                  r_last;
    logic                  r_out_valid;
    logic                  r_busy;
    logic                  r_done;
    logic [2:0]            r_err;
    logic [c_step_w-1:0]   r_step;

    logic signed [XW:0]    w_dx;
    logic signed [YW:0]    w_dy;
    logic signed [XW:0]    w_nx;
    logic signed [YW:0]    w_ny;
    logic                  w_first;
    logic                  w_off_grid;
    logic                  w_loop;
    logic                  w_force_last;
    logic [2:0]            w_err;

    // Decode the predecessor direction into signed x/y offsets (-1, 0, +1).
    always_comb begin
        w_dx = '0;
        w_dy = '0;
        case (rd_dir[2:0])
            3'd0: begin w_dx = '0;      w_dy = '1;      end
            3'd1: begin w_dx = c_x_pos; w_dy = '1;      end
            3'd2: begin w_dx = c_x_pos; w_dy = '0;      end
            3'd3: begin w_dx = c_x_pos; w_dy = c_y_pos; end
            3'd4: begin w_dx = '0;      w_dy = c_y_pos; end
            3'd5: begin w_dx = '1;      w_dy = c_y_pos; end
            3'd6: begin w_dx = '1;      w_dy = '0;      end
            default: begin w_dx = '1;   w_dy = '1;      end
        endcase
    end

    // Next coordinate is one bit wider so that stepping off either edge is visible.
    assign w_nx       = $signed({1'b0, r_cur_x}) + w_dx;
    assign w_ny       = $signed({1'b0, r_cur_y}) + w_dy;
    assign w_first    = (r_step == '0);
    assign w_off_grid = rd_dir[3] & (w_nx[XW] | (w_nx > c_x_max) | w_ny[YW] | (w_ny > c_y_max));
    assign w_loop     = rd_dir[3] & (r_step == c_last_step);

    // Classify the element being read; later checks take precedence over earlier ones.
    always_comb begin
        w_force_last = 1'b0;
        w_err        = 3'd0;
`ifdef PATH_WALKER_MONO_CHECK_EN
        // r_cost still holds the previous element's cost while in WAIT.
        if (!w_first && (rd_cost >= r_cost)) begin
            w_force_last = 1'b1;
            w_err        = 3'd4;
        end
`endif
        if (w_off_grid) begin
            w_force_last = 1'b1;
            w_err        = 3'd2;
        end
        if (w_loop) begin
            w_force_last = 1'b1;
            w_err        = 3'd3;
        end
    end

    // Walk controller: lookup, classify, emit with backpressure, finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rd_en     <= 1'b0;
            r_cur_x     <= '0;
            r_cur_y     <= '0;
            r_next_x    <= '0;
            r_next_y    <= '0;
            r_cost      <= '0;
            r_last      <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 3'd0;
            r_step      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cur_x <= goal_x;
                        r_cur_y <= goal_y;
                        r_err   <= 3'd0;
                        r_step  <= '0;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_rd_en <= 1'b0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_cost <= rd_cost;
                    if (w_first && (rd_cost == c_unreach)) begin
                        r_err   <= 3'd1;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_err       <= w_err;
                        r_last      <= ~rd_dir[3] | w_force_last;
                        r_next_x    <= w_nx[XW-1:0];
                        r_next_y    <= w_ny[YW-1:0];
                        r_out_valid <= 1'b1;
                        r_state     <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_last) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_cur_x <= r_next_x;
                            r_cur_y <= r_next_y;
                            r_step  <= r_step + 1'b1;
                            r_rd_en <= 1'b1;
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_en     = r_rd_en;
    assign rd_x      = r_cur_x;
    assign rd_y      = r_cur_y;
    assign out_valid = r_out_valid;
    assign out_x     = r_cur_x;
    assign out_y     = r_cur_y;
    assign out_cost  = r_cost;
    assign out_last  = r_last;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

`default_nettype wire
